// File: rtl/fetch_stage_if.sv
// Instruction-memory read port shared by fetch_stage and its memory.
// master: the fetch stage issuing reads; slave: the memory answering them.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: requests the word at pc, holds it for decode until
// released by a deasserted stall, and stops for good on an all-zero word.
// Optional feature macro: FETCH_PERF_CNT_EN adds retire_cnt and stall_cnt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   next_pc,
  input  logic          stall,
  fetch_stage_if.master mem,
  output logic [31:0]   pc,
  output logic [31:0]   i_fetch,
  output logic          fetch_valid,
  output logic          halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   retire_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StValid = 2'd2,
    StHalt  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] insn_q, insn_d;
  logic        insn_is_halt;
  logic        retire;
  logic        hold;

  assign insn_is_halt = (insn_q == 32'h0000_0000);
  // A held non-halt word either leaves for the next fetch or waits on stall.
  assign retire       = (state_q == StValid) && !insn_is_halt && !stall;
  assign hold         = (state_q == StValid) && !insn_is_halt && stall;

  // State, pc and instruction registers; reset takes effect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      insn_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
    end
  end

  // Next-state logic; imem_ack only matters while a request is outstanding.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    insn_d  = insn_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (mem.imem_ack) begin
          insn_d  = mem.imem_rdata;
          state_d = StValid;
        end
      end
      StValid: begin
        if (insn_is_halt) begin
          state_d = StHalt;
        end else if (!stall) begin
          // Word-align the target; 32-bit arithmetic wraps naturally.
          pc_d    = {next_pc[31:2], 2'b00};
          state_d = StReq;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded straight from registered state.
  always_comb begin
    mem.imem_req  = (state_q == StReq);
    mem.imem_addr = pc_q;
    pc            = pc_q;
    i_fetch       = insn_q;
    fetch_valid   = (state_q == StValid) || (state_q == StHalt);
    halted        = (state_q == StHalt);
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retire_cnt_q;
  logic [31:0] stall_cnt_q;

  // Performance counters; both wrap at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= 32'h0;
      stall_cnt_q  <= 32'h0;
    end else begin
      if (retire) retire_cnt_q <= retire_cnt_q + 32'h1;
      if (hold)   stall_cnt_q  <= stall_cnt_q + 32'h1;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = retire ^ hold;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations followed by randomized traffic against a transaction model.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] pc;
  logic [31:0] i_fetch;
  logic        fetch_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retire_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .stall       (stall),
    .mem         (bus.master),
    .pc          (pc),
    .i_fetch     (i_fetch),
    .fetch_valid (fetch_valid),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retire_cnt  (retire_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: what fetch has been asked for, what is held, and
  // whether a halt word has been reached.
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_insn = 32'h0;
  bit          m_pending = 0;
  bit          m_have = 0;
  bit          m_halt = 0;
  logic [31:0] m_retired = 32'h0;
  logic [31:0] m_stalls = 32'h0;

  initial begin : model
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_pc = RST_PC; m_insn = 32'h0; m_pending = 0; m_have = 0; m_halt = 0;
        m_retired = 32'h0; m_stalls = 32'h0;
      end else if (m_halt) begin
        // nothing moves once halted
      end else if (m_have) begin
        if (m_insn == 32'h0) begin
          m_halt = 1;
        end else if (stall) begin
          m_stalls = m_stalls + 32'd1;
        end else begin
          m_pc = next_pc & 32'hFFFF_FFFC;
          m_have = 0;
          m_pending = 1;
          m_retired = m_retired + 32'd1;
        end
      end else if (m_pending) begin
        if (bus.imem_ack) begin
          m_insn = bus.imem_rdata;
          m_have = 1;
          m_pending = 0;
        end
      end else begin
        m_pending = 1;  // first cycle out of reset issues nothing
      end
      #1;
      check("m_imem_req", {31'h0, bus.imem_req}, {31'h0, m_pending});
      if (m_pending) check("m_imem_addr", bus.imem_addr, m_pc);
      check("m_pc", pc, m_pc);
      check("m_i_fetch", i_fetch, m_insn);
      check("m_fetch_valid", {31'h0, fetch_valid}, {31'h0, (m_have | m_halt)});
      check("m_halted", {31'h0, halted}, {31'h0, m_halt});
`ifdef FETCH_PERF_CNT_EN
      check("m_retire_cnt", retire_cnt, m_retired);
      check("m_stall_cnt", stall_cnt, m_stalls);
`endif
    end
  end

  task automatic nedge();
    @(negedge clk);
  endtask

  int halt_cycles;

  initial begin : stim
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    nedge(); nedge();
    check("rst_pc", pc, RST_PC);
    check("rst_i_fetch", i_fetch, 32'h0);
    check("rst_valid", {31'h0, fetch_valid}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_req", {31'h0, bus.imem_req}, 32'h0);

    // First fetch, memory answers on the first request cycle.
    rst_n = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2002_0005; stall = 1'b1;
    #1 check("idle_req", {31'h0, bus.imem_req}, 32'h0);
    nedge();
    check("c2_req", {31'h0, bus.imem_req}, 32'h1);
    check("c2_addr", bus.imem_addr, 32'h100);
    check("c2_valid", {31'h0, fetch_valid}, 32'h0);
    nedge();
    check("c3_valid", {31'h0, fetch_valid}, 32'h1);
    check("c3_i_fetch", i_fetch, 32'h2002_0005);
    check("c3_req", {31'h0, bus.imem_req}, 32'h0);
    bus.imem_ack = 1'b0;

    // Five stalled cycles, then release to a misaligned target.
    for (int i = 0; i < 5; i++) begin
      nedge();
      check("stall_pc", pc, 32'h100);
      check("stall_valid", {31'h0, fetch_valid}, 32'h1);
    end
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt5", stall_cnt, 32'd5);
`endif
    stall = 1'b0; next_pc = 32'h0000_0207;
    nedge();
    stall = 1'b1;
    check("rel_pc", pc, 32'h204);
    check("rel_addr", bus.imem_addr, 32'h204);
    check("rel_valid", {31'h0, fetch_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("retire1", retire_cnt, 32'd1);
`endif

    // Memory answers on the fourth request cycle.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nedge();
      check("wait_req", {31'h0, bus.imem_req}, 32'h1);
      check("wait_addr", bus.imem_addr, 32'h204);
      check("wait_valid", {31'h0, fetch_valid}, 32'h0);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    nedge();
    bus.imem_ack = 1'b0;
    check("wait_done", i_fetch, 32'h1234_5678);
    check("wait_done_valid", {31'h0, fetch_valid}, 32'h1);

    // Halt word fetched while decode stalls.
    stall = 1'b0; next_pc = 32'h0000_0303;
    nedge();
    check("h_pc", pc, 32'h300);
    stall = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0;
    nedge();
    bus.imem_ack = 1'b0;
    check("h_held", {31'h0, fetch_valid, halted}, 32'h2);
    nedge();
    check("h_halted", {31'h0, halted}, 32'h1);
    check("h_valid", {31'h0, fetch_valid}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
    check("retire2", retire_cnt, 32'd2);
`endif
    for (int i = 0; i < 4; i++) begin
      stall = 1'(i); bus.imem_ack = 1'b1; next_pc = $urandom;
      nedge();
      check("h_noreq", {31'h0, bus.imem_req}, 32'h0);
      check("h_frozen", pc, 32'h300);
      check("h_still", {31'h0, halted}, 32'h1);
    end
    bus.imem_ack = 1'b0;

    // Reset aborts an outstanding request; a late ack is ignored.
    rst_n = 1'b0;
    nedge();
    rst_n = 1'b1;
    nedge();
    check("r_req", {31'h0, bus.imem_req}, 32'h1);
    nedge();
    rst_n = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("r_async_req", {31'h0, bus.imem_req}, 32'h0);
    check("r_async_valid", {31'h0, fetch_valid}, 32'h0);
    check("r_async_pc", pc, RST_PC);
    nedge();
    rst_n = 1'b1;
    #1;
    check("r_idle_req", {31'h0, bus.imem_req}, 32'h0);
    check("r_idle_i_fetch", i_fetch, 32'h0);
    nedge();
    check("r_new_req", {31'h0, bus.imem_req}, 32'h1);
    check("r_new_addr", bus.imem_addr, RST_PC);
    check("r_new_i_fetch", i_fetch, 32'h0);
    check("r_new_valid", {31'h0, fetch_valid}, 32'h0);

    // Wrap from the top of the address space.
    bus.imem_rdata = 32'h11; stall = 1'b1;
    nedge();
    bus.imem_ack = 1'b0; stall = 1'b0; next_pc = 32'hFFFF_FFFE;
    nedge();
    check("w_top", pc, 32'hFFFF_FFFC);
    check("w_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h22; next_pc = 32'h0;
    nedge();
    check("w_top_insn", i_fetch, 32'h22);
    bus.imem_ack = 1'b0;
    nedge();
    check("w_zero", pc, 32'h0);
    check("w_zero_req", {31'h0, bus.imem_req}, 32'h1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h33;
    nedge();
    check("w_zero_insn", i_fetch, 32'h33);
    check("w_zero_valid", {31'h0, fetch_valid}, 32'h1);
    bus.imem_ack = 1'b0; stall = 1'b1;

    // Randomized traffic, reset pulses and recovery from halts.
    halt_cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      nedge();
      halt_cycles = halted ? halt_cycles + 1 : 0;
      rst_n = !(($urandom_range(0, 199) == 0) || (halt_cycles > 3));
      stall = ($urandom_range(0, 2) == 0);
      next_pc = $urandom;
      bus.imem_ack = bus.imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      bus.imem_rdata = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
    end
    nedge();
    nedge();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
